// File: rtl/csa_stream_accumulator.sv
// Streaming unsigned accumulator: carry-save fold per beat, chunked carry-propagate resolve.
// Optional sticky overflow output enabled by defining CSA_ACC_OVF_EN.
module csa_stream_accumulator #(
  parameter int N        = 8,
  parameter int EXT_BITS = 4,
  parameter int CHUNK    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [N-1:0]          i_in_data,
  input  logic                  i_in_last,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
`ifdef CSA_ACC_OVF_EN
  output logic                  o_out_ovf,
`endif
  output logic [N+EXT_BITS-1:0] o_out_data
);

  localparam int W  = N + EXT_BITS;
  localparam int R  = (W + CHUNK - 1) / CHUNK;
  localparam int JW = (R > 1) ? $clog2(R) : 1;
`ifdef CSA_ACC_OVF_EN
  localparam int CW = W;
`else
  localparam int CW = W - 1;
`endif
  localparam logic [W-1:0] CH_MASK = {W{1'b1}} >> (W - CHUNK);

  typedef enum logic [1:0] {ST_ACCUM, ST_RESOLVE, ST_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_s;
  // The top carry bit (weight 2^W) is only ever needed for overflow detection.
  logic [CW-1:0]   r_c;
  logic            r_cy;
  logic [JW-1:0]   r_j;

  logic [W-1:0]    w_a, w_c2, w_acc_s, w_mask, w_res_s, w_c2_clr;
  logic [CW-1:0]   w_acc_c, w_res_c;
  logic [CHUNK-1:0] w_s_ch, w_c2_ch;
  logic [CHUNK:0]  w_sum;
  logic            w_cy_out, w_last_chunk;
  int              w_base, w_rem;

  assign w_a     = {{EXT_BITS{1'b0}}, i_in_data};
  assign w_c2    = {r_c[W-2:0], 1'b0};
  assign w_acc_s = w_a ^ r_s ^ w_c2;
  assign w_acc_c = CW'((w_a & r_s) | (w_a & w_c2) | (r_s & w_c2));

  assign w_base       = int'(r_j) * CHUNK;
  assign w_rem        = W - w_base;
  assign w_mask       = CH_MASK << w_base;
  assign w_s_ch       = CHUNK'(r_s >> w_base);
  assign w_c2_ch      = CHUNK'(w_c2 >> w_base);
  assign w_sum        = {1'b0, w_s_ch} + {1'b0, w_c2_ch} + {{CHUNK{1'b0}}, r_cy};
  assign w_res_s      = (r_s & ~w_mask) | ((W'(w_sum[CHUNK-1:0]) << w_base) & w_mask);
  assign w_c2_clr     = w_c2 & ~w_mask;
  assign w_res_c      = CW'({1'b0, w_c2_clr[W-1:1]});
  assign w_last_chunk = (r_j == JW'(R - 1));

  // A narrower final chunk takes its carry from the bit just above its own width.
  always_comb begin
    w_cy_out = 1'b0;
    for (int k = 1; k <= CHUNK; k++) begin
      if (k == ((w_rem >= CHUNK) ? CHUNK : w_rem)) w_cy_out = w_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM:   if (i_in_valid && i_in_last) w_state_nxt = ST_RESOLVE;
      ST_RESOLVE: if (w_last_chunk)            w_state_nxt = ST_DONE;
      ST_DONE:    if (i_out_ready)             w_state_nxt = ST_ACCUM;
      default:                                 w_state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == ST_ACCUM);
    o_out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s  <= '0;
      r_c  <= '0;
      r_cy <= 1'b0;
      r_j  <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: if (i_in_valid) begin
          r_s <= w_acc_s;
          r_c <= w_acc_c;
          if (i_in_last) begin
            r_j  <= '0;
            r_cy <= 1'b0;
          end
        end
        ST_RESOLVE: begin
          r_s  <= w_res_s;
          r_c  <= w_res_c;
          r_cy <= w_cy_out;
          r_j  <= r_j + 1'b1;
        end
        ST_DONE: if (i_out_ready) begin
          r_s  <= '0;
          r_c  <= '0;
          r_cy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic r_ovf;
  // The last beat's top carry is also dropped by the resolve shift, so it counts too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM:   if (i_in_valid)
                      r_ovf <= r_ovf | r_c[W-1] | (i_in_last & w_acc_c[W-1]);
        ST_RESOLVE: if (w_last_chunk) r_ovf <= r_ovf | w_cy_out;
        ST_DONE:    if (i_out_ready)  r_ovf <= 1'b0;
        default: ;
      endcase
    end
  end
  assign o_out_ovf = r_ovf;
`endif

  assign o_out_data = r_s;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator: directed packets, monitor pops on out handshake.
module tb_csa_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid, i_in_last, i_out_ready;
  logic [7:0]  i_in_data;
  logic        o_in_ready, o_out_valid;
  logic [11:0] o_out_data;
`ifdef CSA_ACC_OVF_EN
  logic        o_out_ovf;
`endif

  typedef struct packed {
    logic [11:0] d;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  csa_stream_accumulator #(.N(8), .EXT_BITS(4), .CHUNK(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .i_in_last  (i_in_last),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
`ifdef CSA_ACC_OVF_EN
    .o_out_ovf  (o_out_ovf),
`endif
    .o_out_data (o_out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] d, input logic ovf);
    exp_t e;
    e.d   = d;
    e.ovf = ovf;
    q.push_back(e);
  endtask

  // Leaves i_in_valid high so consecutive beats go out without bubbles.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int g = 0;
    i_in_valid = 1'b1;
    i_in_data  = d;
    i_in_last  = last;
    while (!o_in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!o_out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 50) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!o_in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("idle_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", int'(o_out_data), -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", int'(o_out_data), int'(e.d));
`ifdef CSA_ACC_OVF_EN
        chk("out_ovf", int'(o_out_ovf), int'(e.ovf));
`endif
      end
    end
  end

  initial begin
    int lat;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_in_last   = 1'b0;
    i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(o_in_ready), 1);
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_out_data", int'(o_out_data), 0);
`ifdef CSA_ACC_OVF_EN
    chk("rst_out_ovf", int'(o_out_ovf), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic sum
    push(12'h2FD, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b1);
    i_in_valid = 1'b0;
    wait_out(lat);
    chk("basic_latency", lat, 3);
    wait_idle();

    // single operand, in_ready low through RESOLVE and DONE
    push(12'h05A, 1'b0);
    send_beat(8'h5A, 1'b1);
    i_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("single_ready_resolve", int'(o_in_ready), 0);
      chk("single_valid_resolve", int'(o_out_valid), 0);
      @(posedge clk); #1;
    end
    chk("single_valid_done", int'(o_out_valid), 1);
    chk("single_ready_done", int'(o_in_ready), 0);
    wait_idle();

    // wrap and overflow
    push(12'h0EF, 1'b1);
    for (int i = 0; i < 17; i++) send_beat(8'hFF, (i == 16));
    i_in_valid = 1'b0;
    wait_out(lat);
    chk("wrap_latency", lat, 3);
    wait_idle();

    // output backpressure with in_valid held
    i_out_ready = 1'b0;
    push(12'h033, 1'b0);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    i_in_valid = 1'b0;
    wait_out(lat);
    i_in_valid = 1'b1;
    i_in_data  = 8'h77;
    i_in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", int'(o_out_valid), 1);
      chk("bp_data", int'(o_out_data), 12'h033);
      chk("bp_in_ready", int'(o_in_ready), 0);
      @(posedge clk); #1;
    end
    push(12'h077, 1'b0);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", int'(o_in_ready), 1);
    chk("bp_valid_after_hs", int'(o_out_valid), 0);
    @(posedge clk); #1;
    chk("bp_next_accepted", int'(o_in_ready), 0);
    i_in_valid = 1'b0;
    wait_out(lat);
    chk("bp_next_latency", lat, 3);
    wait_idle();

    // reset during the second RESOLVE cycle discards the packet
    send_beat(8'h40, 1'b1);
    i_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(o_out_valid), 0);
    chk("midrst_in_ready", int'(o_in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(12'h001, 1'b0);
    send_beat(8'h01, 1'b1);
    i_in_valid = 1'b0;
    wait_out(lat);
    wait_idle();

    // back-to-back packets
    push(12'h030, 1'b0);
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b1);
    i_in_valid = 1'b0;
    wait_out(lat);
    push(12'h003, 1'b0);
    send_beat(8'h03, 1'b1);
    i_in_valid = 1'b0;
    wait_out(lat);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
